// File: rtl/pwm_bank.sv
// Multi-channel PWM: one prescaled period counter shared by all channels, shadowed
// settings that switch over only at a period boundary, and an optional per-channel duty ramp.
module pwm_bank #(
  parameter int CHANNELS = 2,
  parameter int W        = 27,
  parameter int PRESC_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [PRESC_W-1:0]    presc_i,
  input  logic [W-1:0]          period_i,
  input  logic [CHANNELS*W-1:0] duty_i,
  input  logic [CHANNELS-1:0]   mode_i,
  input  logic [W-1:0]          step_i,
  input  logic                  load_i,
  output logic                  pending_o,
  output logic                  period_start_o,
  output logic [CHANNELS-1:0]   out_o
);

  logic [PRESC_W-1:0]             pcnt_q, pcnt_d;
  logic [W-1:0]                   cnt_q, cnt_d;
  logic [W-1:0]                   per_a_q, per_a_d, step_a_q, step_a_d;
  logic [CHANNELS-1:0]            mode_a_q, mode_a_d;
  logic [CHANNELS-1:0][W-1:0]     dwork_q, dwork_d;
  logic [CHANNELS-1:0]            down_q, down_d;
  logic [W-1:0]                   per_s_q, per_s_d, step_s_q, step_s_d;
  logic [CHANNELS*W-1:0]          duty_s_q, duty_s_d;
  logic [CHANNELS-1:0]            mode_s_q, mode_s_d;
  logic                           pending_q, pending_d;
  logic                           bnd_q, bnd_d, pstart_q, pstart_d;
  logic [CHANNELS-1:0]            out_q, out_d;
  logic                           tick, bnd, apply;
  logic [W:0]                     up_sum;

  always_comb begin
    tick   = enable_i && (pcnt_q == presc_i);
    bnd    = tick && (cnt_q >= per_a_q);
    // While stopped there is no boundary to wait for, so a pending shadow lands at once.
    apply  = pending_q && (bnd || !enable_i);
    pcnt_d = (!enable_i || (pcnt_q >= presc_i)) ? '0 : pcnt_q + PRESC_W'(1);

    cnt_d = cnt_q;
    if (!enable_i)  cnt_d = '0;
    else if (tick)  cnt_d = bnd ? '0 : cnt_q + W'(1);

    per_a_d   = per_a_q;
    step_a_d  = step_a_q;
    mode_a_d  = mode_a_q;
    dwork_d   = dwork_q;
    down_d    = down_q;
    per_s_d   = per_s_q;
    step_s_d  = step_s_q;
    duty_s_d  = duty_s_q;
    mode_s_d  = mode_s_q;
    pending_d = pending_q;
    up_sum    = '0;

    if (apply) begin
      per_a_d   = per_s_q;
      step_a_d  = step_s_q;
      mode_a_d  = mode_s_q;
      down_d    = '0;
      pending_d = 1'b0;
      for (int i = 0; i < CHANNELS; i++)
        dwork_d[i] = mode_s_q[i] ? '0 : duty_s_q[i*W +: W];
    end else if (bnd) begin
      // One extra bit keeps dwork+step from wrapping before the compare against the period.
      for (int i = 0; i < CHANNELS; i++) begin
        if (mode_a_q[i]) begin
          up_sum = {1'b0, dwork_q[i]} + {1'b0, step_a_q};
          if (!down_q[i]) begin
            if (up_sum >= {1'b0, per_a_q}) begin
              dwork_d[i] = per_a_q;
              down_d[i]  = 1'b1;
            end else begin
              dwork_d[i] = up_sum[W-1:0];
            end
          end else if (dwork_q[i] <= step_a_q) begin
            dwork_d[i] = '0;
            down_d[i]  = 1'b0;
          end else begin
            dwork_d[i] = dwork_q[i] - step_a_q;
          end
        end
      end
    end

    if (load_i) begin
      per_s_d   = period_i;
      step_s_d  = step_i;
      duty_s_d  = duty_i;
      mode_s_d  = mode_i;
      pending_d = 1'b1;
    end

    for (int i = 0; i < CHANNELS; i++)
      out_d[i] = enable_i && (cnt_q < dwork_q[i]);
    bnd_d    = bnd;
    pstart_d = enable_i && bnd_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q    <= '0;
      cnt_q     <= '0;
      per_a_q   <= '0;
      step_a_q  <= '0;
      mode_a_q  <= '0;
      dwork_q   <= '0;
      down_q    <= '0;
      per_s_q   <= '0;
      step_s_q  <= '0;
      duty_s_q  <= '0;
      mode_s_q  <= '0;
      pending_q <= 1'b0;
      bnd_q     <= 1'b0;
      pstart_q  <= 1'b0;
      out_q     <= '0;
    end else begin
      pcnt_q    <= pcnt_d;
      cnt_q     <= cnt_d;
      per_a_q   <= per_a_d;
      step_a_q  <= step_a_d;
      mode_a_q  <= mode_a_d;
      dwork_q   <= dwork_d;
      down_q    <= down_d;
      per_s_q   <= per_s_d;
      step_s_q  <= step_s_d;
      duty_s_q  <= duty_s_d;
      mode_s_q  <= mode_s_d;
      pending_q <= pending_d;
      bnd_q     <= bnd_d;
      pstart_q  <= pstart_d;
      out_q     <= out_d;
    end
  end

  assign pending_o      = pending_q;
  assign period_start_o = pstart_q;
  assign out_o          = out_q;

endmodule
